// File: rtl/updown_mod_counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Saturating mode is selected by the UPDOWN_MOD_COUNTER_SAT_EN macro in the top level.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Prescaler counter width; a single bit is kept even when PRESCALE is 1.
  function automatic int unsigned ps_width(input int unsigned prescale);
    if (prescale <= 1) begin
      return 1;
    end
    return $clog2(prescale);
  endfunction

  // Out-of-range load values land on the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] mod);
    if (val >= mod) begin
      return mod - 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// Enable-gated tick divider: emits a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE=1 the phase register is constant and tick follows en.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PS_W   = ps_width(PRESCALE);
  localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PsOne  = PS_W'(1);

  logic [PS_W-1:0] r_phase;
  logic            w_last;

  assign w_last = (r_phase == PsLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_last ? '0 : r_phase + PsOne;
    end
  end

  assign tick = en & ~clr & w_last;

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with prescaler, parallel load, tc and wrap flags.
// Define UPDOWN_MOD_COUNTER_SAT_EN for saturating steps (wrap tied low).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_tick;
  logic             w_at_bound;
  dir_t             w_dir;

  assign w_dir          = dir_t'(up_dn);
  assign w_load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
  assign w_at_bound     = (w_dir == DIR_UP) ? (r_count == CntMax) : (r_count == '0);

  // A load also restarts the prescale phase.
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  always_comb begin
    w_count_d = r_count;
    if (load) begin
      w_count_d = w_load_clamped;
    end else if (w_tick) begin
      if (w_at_bound) begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        w_count_d = r_count;
`else
        w_count_d = (w_dir == DIR_UP) ? '0 : CntMax;
`endif
      end else begin
        w_count_d = (w_dir == DIR_UP) ? r_count + CntOne : r_count - CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  logic r_wrap;
  logic w_wrap_d;

  assign w_wrap_d = ~load & w_tick & w_at_bound;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_d;
    end
  end

  assign wrap = r_wrap;
`endif

  assign count = r_count;
  assign tc    = w_at_bound;

endmodule
